lisnoc_measure_sink: RTL

- Synthesizable packet sink and statistics collector on one mesh output link (a mesh `links_out` port) in the measurement setup.
- Consumes flits per virtual channel under a programmable backpressure mask and checks packet framing per VC.
- Computes end-to-end latency from a timestamp carried in each header flit.
- Exposes saturating counters that the measurement environment reads at end of run.

---
 rtl/lisnoc_measure_sink.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/lisnoc_measure_sink.sv
// Packet sink and statistics collector for one mesh output link.
// Checks per-VC framing, measures header-timestamp latency, keeps saturating counters.
module lisnoc_measure_sink #(
  parameter int vchannels       = 1,
  parameter int flit_data_width = 32,
  parameter int flit_type_width = 2,
  parameter int ts_width        = 16,
  localparam int flit_width     = flit_data_width + flit_type_width
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [flit_width-1:0] in_flit,
  input  logic [vchannels-1:0]  in_valid,
  output logic [vchannels-1:0]  in_ready,
  input  logic [vchannels-1:0]  stall_mask,
  input  logic [ts_width-1:0]   now,
  input  logic                  clear,
  output logic [31:0]           pkt_count,
  output logic [31:0]           flit_count,
  output logic [47:0]           lat_sum,
  output logic [ts_width-1:0]   lat_max,
  output logic [15:0]           err_count,
  output logic [vchannels-1:0]  active
);

  typedef enum logic {IDLE = 1'b0, PKT = 1'b1} state_e;

  localparam logic [1:0] T_PAYLOAD = 2'b00;
  localparam logic [1:0] T_HEADER  = 2'b01;
  localparam logic [1:0] T_LAST    = 2'b10;
  localparam logic [1:0] T_SINGLE  = 2'b11;

  state_e              state_q [vchannels];
  state_e              state_d [vchannels];
  logic [ts_width-1:0] ts_q    [vchannels];
  logic [ts_width-1:0] ts_d    [vchannels];

  logic [vchannels-1:0] want, grant;
  logic                 conflict, accept, complete, frame_err;
  logic [1:0]           ftype;
  logic [ts_width-1:0]  fts, lat_ts, lat;

  logic [31:0]         pkt_count_q, pkt_count_d, flit_count_q, flit_count_d;
  logic [47:0]         lat_sum_q, lat_sum_d;
  logic [48:0]         sum_wide;
  logic [ts_width-1:0] lat_max_q, lat_max_d;
  logic [15:0]         err_count_q, err_count_d;
  logic [16:0]         err_wide;
  logic                unused_flit_bits;

  // Lowest-index wanting VC wins; the losers see ready dropped this cycle.
  assign want     = in_valid & ~stall_mask & {vchannels{~rst}};
  assign grant    = want & (~want + vchannels'(1));
  assign conflict = |(want & ~grant);
  assign accept   = |grant;
  assign in_ready = ~stall_mask & {vchannels{~rst}} & ~(want & ~grant);

  assign ftype            = in_flit[flit_data_width +: 2];
  assign fts              = in_flit[ts_width-1:0];
  assign unused_flit_bits = ^in_flit;
  assign lat              = now - lat_ts;

  // Per-VC framing next state, completion detection and latency source
  always_comb begin
    complete  = 1'b0;
    frame_err = 1'b0;
    lat_ts    = fts;
    active    = '0;
    for (int v = 0; v < vchannels; v++) begin
      state_d[v] = state_q[v];
      ts_d[v]    = ts_q[v];
      active[v]  = (state_q[v] == PKT);
      if (grant[v]) begin
        unique case (ftype)
          T_HEADER: begin
            frame_err  = (state_q[v] == PKT);
            state_d[v] = PKT;
            ts_d[v]    = fts;
          end
          T_SINGLE: begin
            frame_err  = (state_q[v] == PKT);
            state_d[v] = IDLE;
            complete   = 1'b1;
          end
          T_PAYLOAD: begin
            frame_err = (state_q[v] == IDLE);
          end
          T_LAST: begin
            if (state_q[v] == PKT) begin
              complete = 1'b1;
              lat_ts   = ts_q[v];
            end else begin
              frame_err = 1'b1;
            end
            state_d[v] = IDLE;
          end
          default: begin
            state_d[v] = state_q[v];
          end
        endcase
      end else begin
        state_d[v] = state_q[v];
      end
    end
  end

  // Saturating statistics next state
  always_comb begin
    pkt_count_d  = pkt_count_q;
    flit_count_d = flit_count_q;
    lat_sum_d    = lat_sum_q;
    lat_max_d    = lat_max_q;
    sum_wide     = {1'b0, lat_sum_q} + 49'(lat);
    err_wide     = {1'b0, err_count_q} + 17'(conflict) + 17'(frame_err);
    err_count_d  = err_wide[16] ? 16'hFFFF : err_wide[15:0];
    if (accept && flit_count_q != 32'hFFFF_FFFF) begin
      flit_count_d = flit_count_q + 32'd1;
    end else begin
      flit_count_d = flit_count_q;
    end
    if (complete) begin
      if (pkt_count_q != 32'hFFFF_FFFF) begin
        pkt_count_d = pkt_count_q + 32'd1;
      end else begin
        pkt_count_d = pkt_count_q;
      end
      lat_sum_d = sum_wide[48] ? 48'hFFFF_FFFF_FFFF : sum_wide[47:0];
      if (lat > lat_max_q) begin
        lat_max_d = lat;
      end else begin
        lat_max_d = lat_max_q;
      end
    end else begin
      lat_sum_d = lat_sum_q;
    end
  end

  // Statistics registers; clear overrides a same-cycle update
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pkt_count_q  <= 32'd0;
      flit_count_q <= 32'd0;
      lat_sum_q    <= 48'd0;
      lat_max_q    <= '0;
      err_count_q  <= 16'd0;
    end else begin
      pkt_count_q  <= pkt_count_d;
      flit_count_q <= flit_count_d;
      lat_sum_q    <= lat_sum_d;
      lat_max_q    <= lat_max_d;
      err_count_q  <= err_count_d;
    end
  end

  // Framing state and latched header timestamps; clear leaves these alone
  always_ff @(posedge clk) begin
    for (int v = 0; v < vchannels; v++) begin
      if (rst) begin
        state_q[v] <= IDLE;
        ts_q[v]    <= '0;
      end else begin
        state_q[v] <= state_d[v];
        ts_q[v]    <= ts_d[v];
      end
    end
  end

  assign pkt_count  = pkt_count_q;
  assign flit_count = flit_count_q;
  assign lat_sum    = lat_sum_q;
  assign lat_max    = lat_max_q;
  assign err_count  = err_count_q;

endmodule
